// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, default sizes and pointer-width helper for mem_arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int NUM_REQ_DEF = 4;
    localparam int AW_DEF = 64;
    localparam int DW_DEF = 64;
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: rotate-and-priority-encode, first asserted request at or after the pointer.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_idx,
    output logic          o_vld
);
    always_comb begin
        o_idx = '0;
        o_vld = |i_req;
        for (int i = N - 1; i >= 0; i--)
            if (i_req[(int'(i_ptr) + i) % N]) o_idx = PW'((int'(i_ptr) + i) % N);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter serialising NUM_REQ requesters onto one single-outstanding memory port.
// Define MEM_ARB_RMW_LOCK_EN to hold the grant across a read-then-write pair.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ-1:0]    wr_i,
    input  logic [NUM_REQ*AW-1:0] addr_i,
    input  logic [NUM_REQ*DW-1:0] wdata_i,
    output logic [NUM_REQ-1:0]    rdy_o,
    output logic [DW-1:0]         rdata_o,
    output logic                  m_req,
    output logic                  m_wr,
    output logic [AW-1:0]         m_addr,
    output logic [DW-1:0]         m_dout,
    input  logic [DW-1:0]         m_din,
    input  logic                  m_rdy
);
    localparam int PW = clog2(NUM_REQ);

    state_t               r_state, w_next;
    logic [PW-1:0]        r_ptr, r_g, w_idx, w_g_nxt;
    logic [NUM_REQ-1:0]   w_req;
    logic                 w_vld, w_adv;

    assign w_g_nxt = (r_g == PW'(NUM_REQ - 1)) ? '0 : r_g + 1'b1;

`ifdef MEM_ARB_RMW_LOCK_EN
    localparam int CW = clog2(LOCK_TIMEOUT + 1);
    logic          r_lock, w_idle_g, w_expire;
    logic [CW-1:0] r_cnt;

    // While locked only the owner can win; its idle cycles count toward release.
    assign w_req    = r_lock ? req_i & (NUM_REQ'(1) << r_g) : req_i;
    assign w_idle_g = r_lock && r_state == IDLE && !req_i[r_g];
    assign w_expire = w_idle_g && r_cnt == CW'(LOCK_TIMEOUT - 1);
    assign w_adv    = (r_state == DONE && m_wr) || w_expire;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_lock <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_cnt <= w_idle_g ? r_cnt + 1'b1 : '0;
            if (r_state == DONE) r_lock <= !m_wr;
            else if (w_expire) r_lock <= 1'b0;
        end
`else
    logic w_unused_lock;
    assign w_req         = req_i;
    assign w_adv         = r_state == DONE;
    assign w_unused_lock = LOCK_TIMEOUT > 0;
`endif

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .i_req(w_req),
        .i_ptr(r_ptr),
        .o_idx(w_idx),
        .o_vld(w_vld)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;

    always_comb
        w_next = r_state == IDLE ? (w_vld ? BUSY : IDLE) :
                 r_state == BUSY ? (m_rdy ? DONE : BUSY) : IDLE;

    always_comb begin
        m_req = r_state == BUSY;
        rdy_o = r_state == DONE ? NUM_REQ'(1) << r_g : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_g     <= '0;
            m_wr    <= 1'b0;
            m_addr  <= '0;
            m_dout  <= '0;
            rdata_o <= '0;
        end else begin
            if (r_state == IDLE && w_vld) begin
                r_g    <= w_idx;
                m_wr   <= wr_i[w_idx];
                m_addr <= addr_i[int'(w_idx) * AW +: AW];
                m_dout <= wdata_i[int'(w_idx) * DW +: DW];
            end
            if (r_state == BUSY && m_rdy) rdata_o <= m_din;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_ptr <= '0;
        else if (w_adv) r_ptr <= w_g_nxt;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a latency-programmable memory responder.
module tb_mem_arbiter;
    localparam int N = 4, AW = 64, DW = 64;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]    req_i = '0, wr_i = '0, rdy_o;
    logic [N*AW-1:0] addr_i = '0;
    logic [N*DW-1:0] wdata_i = '0;
    logic [DW-1:0]   rdata_o, m_dout, m_din = '0;
    logic [AW-1:0]   m_addr;
    logic            m_req, m_wr, m_rdy = 1'b0;
    logic [DW-1:0]   mem [256];
    int checks = 0, errors = 0, lat = 1;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .LOCK_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdy_o(rdy_o), .rdata_o(rdata_o), .m_req(m_req),
        .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din), .m_rdy(m_rdy)
    );

    // Memory: answers lat cycles after m_req rises, applying writes to mem.
    initial begin : responder
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            m_rdy = 1'b0;
            if (!m_req) c = 0;
            else begin
                c++;
                if (c == lat) begin
                    m_rdy = 1'b1;
                    if (m_wr) mem[m_addr[7:0]] = m_dout;
                    m_din = m_wr ? '0 : mem[m_addr[7:0]];
                end
            end
        end
    end

    task automatic set_req(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_i[k] = w;
        addr_i[k*AW +: AW] = a;
        wdata_i[k*DW +: DW] = d;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_i = '0;
        wr_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_req(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!m_req && n < 100);
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (rdy_o == '0 && n < 100);
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({m_req, m_wr, m_addr, m_dout, rdy_o, rdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b wr=%b addr=%0h dout=%0h rdy=%b rdata=%0h exp all 0",
                     m_req, m_wr, m_addr, m_dout, rdy_o, rdata_o);
        end
    endtask

    task automatic test_single_read;
        int n;
        do_reset;
        lat = 2;
        mem[8'h10] = 64'hDEAD_BEEF;
        set_req(2, 1'b0, 64'h10, '0);
        req_i = 4'b0100;
        wait_req(n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL single_req_delay got %0d exp 1", n); end
        checks++;
        if (m_addr !== 64'h10) begin errors++; $display("FAIL single_addr got %0h exp 10", m_addr); end
        checks++;
        if (m_wr !== 1'b0) begin errors++; $display("FAIL single_wr got %b exp 0", m_wr); end
        wait_rdy(n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL single_latency got %0d exp 2", n); end
        checks++;
        if (rdy_o !== 4'b0100) begin errors++; $display("FAIL single_rdy got %b exp 0100", rdy_o); end
        checks++;
        if (rdata_o !== 64'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata got %0h exp deadbeef", rdata_o); end
        req_i = '0;
        @(negedge clk);
        checks++;
        if (rdy_o !== 4'b0000) begin errors++; $display("FAIL single_rdy_pulse got %b exp 0000", rdy_o); end
    endtask

    task automatic test_round_robin;
        int n;
        logic [N-1:0] e;
        do_reset;
        lat = 1;
        for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k), '0);
        req_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            wait_rdy(n);
            e = 4'b0001 << (i % N);
            checks++;
            if (rdy_o !== e) begin errors++; $display("FAIL rr_order_%0d got %b exp %b", i, rdy_o, e); end
            if (i > 0) begin
                checks++;
                if (n !== 3) begin errors++; $display("FAIL rr_gap_%0d got %0d exp 3", i, n); end
            end
        end
        req_i = '0;
        @(negedge clk);
    endtask

    task automatic test_write_then_other;
        int n;
        do_reset;
        lat = 3;
        mem[8'h20] = 64'h77;
        mem[8'hFF] = '0;
        set_req(1, 1'b1, 64'hFF, 64'h5);
        set_req(3, 1'b0, 64'h20, '0);
        req_i = 4'b1010;
        wait_req(n);
        checks++;
        if ({m_wr, m_addr, m_dout} !== {1'b1, 64'hFF, 64'h5}) begin
            errors++;
            $display("FAIL wr_cmd got wr=%b addr=%0h dout=%0h exp wr=1 addr=ff dout=5", m_wr, m_addr, m_dout);
        end
        wait_rdy(n);
        checks++;
        if (rdy_o !== 4'b0010) begin errors++; $display("FAIL wr_rdy got %b exp 0010", rdy_o); end
        req_i[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (mem[8'hFF] !== 64'h5) begin errors++; $display("FAIL wr_mem got %0h exp 5", mem[8'hFF]); end
        wait_req(n);
        checks++;
        if ({m_wr, m_addr} !== {1'b0, 64'h20}) begin
            errors++;
            $display("FAIL next_cmd got wr=%b addr=%0h exp wr=0 addr=20", m_wr, m_addr);
        end
        checks++;
        if (rdy_o !== 4'b0000) begin errors++; $display("FAIL early_rdy got %b exp 0000", rdy_o); end
        wait_rdy(n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL next_latency got %0d exp 3", n); end
        checks++;
        if (rdy_o !== 4'b1000) begin errors++; $display("FAIL next_rdy got %b exp 1000", rdy_o); end
        checks++;
        if (rdata_o !== 64'h77) begin errors++; $display("FAIL next_rdata got %0h exp 77", rdata_o); end
        req_i = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy;
        int n;
        do_reset;
        lat = 1;
        set_req(1, 1'b0, 64'h1, '0);
        req_i = 4'b0010;
        wait_rdy(n);
        req_i = '0;
        mem[8'h05] = 64'hAA;
        mem[8'h06] = 64'hBB;
        set_req(1, 1'b0, 64'h5, '0);
        set_req(2, 1'b0, 64'h6, '0);
        lat = 10;
        req_i = 4'b0110;
        wait_req(n);
        checks++;
        if (m_addr !== 64'h6) begin errors++; $display("FAIL abort_grant_addr got %0h exp 6", m_addr); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_req, rdy_o, m_addr} !== '0) begin
            errors++;
            $display("FAIL abort_async got req=%b rdy=%b addr=%0h exp all 0", m_req, rdy_o, m_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        lat = 1;
        wait_rdy(n);
        checks++;
        if (rdy_o !== 4'b0010) begin errors++; $display("FAIL abort_next_rdy got %b exp 0010", rdy_o); end
        checks++;
        if (rdata_o !== 64'hAA) begin errors++; $display("FAIL abort_next_rdata got %0h exp aa", rdata_o); end
        req_i = '0;
        @(negedge clk);
    endtask

`ifdef MEM_ARB_RMW_LOCK_EN
    task automatic test_rmw_lock;
        int n, k;
        do_reset;
        lat = 1;
        mem[8'h20] = '0;
        set_req(0, 1'b0, 64'h20, '0);
        set_req(1, 1'b0, 64'h20, '0);
        req_i = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            wait_rdy(n);
            k = rdy_o[1] ? 1 : 0;
            checks++;
            if (k * 2 + int'(m_wr) !== i) begin
                errors++;
                $display("FAIL rmw_seq_%0d got req%0d wr=%b exp req%0d wr=%0d", i, k, m_wr, i / 2, i % 2);
            end
            if (!m_wr) set_req(k, 1'b1, 64'h20, rdata_o + 1);
            else req_i[k] = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (mem[8'h20] !== 64'h2) begin errors++; $display("FAIL rmw_final got %0h exp 2", mem[8'h20]); end
    endtask

    task automatic test_lock_timeout;
        int n;
        do_reset;
        lat = 1;
        set_req(0, 1'b0, 64'h30, '0);
        set_req(1, 1'b0, 64'h40, '0);
        req_i = 4'b0011;
        wait_rdy(n);
        checks++;
        if (rdy_o !== 4'b0001) begin errors++; $display("FAIL lock_first_rdy got %b exp 0001", rdy_o); end
        req_i[0] = 1'b0;
        wait_req(n);
        checks++;
        if (n !== 17) begin errors++; $display("FAIL lock_timeout_delay got %0d exp 17", n); end
        checks++;
        if (m_addr !== 64'h40) begin errors++; $display("FAIL lock_timeout_addr got %0h exp 40", m_addr); end
        wait_rdy(n);
        req_i = '0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset;
        test_single_read;
        test_round_robin;
        test_write_then_other;
        test_reset_mid_busy;
`ifdef MEM_ARB_RMW_LOCK_EN
        test_rmw_lock;
        test_lock_timeout;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
